core_mem_copy_master: RTL and testbench
=======================================

Name: core_mem_copy_master

Overview:
- Avalon-MM master that drives the single-port on-chip RAM slave: 13-bit word address, 32-bit data, byteenable, chipselect/write, fixed read latency 1.
- Copies a block of words from one address range to another in that RAM, or fills a range with a constant.
- Accumulates a 32-bit checksum of the words written.
- Sits beside each core's on-chip memory; the control side is driven by a core-local register block.

Parameters:
- ADDR_W, 13, word-address width of the memory port
- DATA_W, 32, data width; byteenable width is DATA_W/8
- LEN_W, 14, width of the length field (0..8192 words)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle command strobe; sampled only in IDLE
- mode  in  1  0 = copy, 1 = fill
- src_addr  in  ADDR_W  copy source word address
- dst_addr  in  ADDR_W  destination word address
- length  in  LEN_W  number of words to transfer
- fill_value  in  DATA_W  word written in fill mode
- abort  in  1  stop transfer after the current access
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- aborted  out  1  set when the last transfer ended by abort
- checksum  out  DATA_W  sum of words written, mod 2^DATA_W
- words_done  out  LEN_W  number of words written by the last/current transfer
- mem_address  out  ADDR_W  memory address
- mem_byteenable  out  DATA_W/8  always all ones
- mem_chipselect  out  1  memory access qualifier
- mem_write  out  1  write strobe (write = chipselect & write)
- mem_writedata  out  DATA_W  write data
- mem_clken  out  1  memory clock enable; equals busy
- mem_readdata  in  DATA_W  memory read data, valid the cycle after a read access

Behaviour:
- Reset (async, reset_n=0): state IDLE.
  - busy, done, aborted = 0; checksum, words_done = 0.
  - mem_chipselect, mem_write = 0; mem_address, mem_writedata = 0; mem_clken = 0.
- States: IDLE, RD, WR, FILL, FIN.
- IDLE:
  - start=1 latches src_addr, dst_addr, length, mode and fill_value into working registers.
  - Clears checksum, words_done and aborted.
  - Next state is FIN if length=0, else RD (copy) or FILL (fill).
  - start in any other state is ignored.
- RD:
  - mem_chipselect=1, mem_write=0, mem_address=src pointer.
  - Next state is WR.
- WR:
  - mem_chipselect=1, mem_write=1, mem_address=dst pointer, mem_writedata=mem_readdata (combinational pass-through of the data returned for the preceding RD).
  - checksum += mem_readdata; src and dst pointers +1; words_done +1.
  - Next state is FIN if the remaining count reaches 0 or abort=1, else RD.
- FILL:
  - mem_chipselect=1, mem_write=1, mem_address=dst pointer, mem_writedata=fill_value.
  - checksum += fill_value; dst pointer +1; words_done +1.
  - Next state is FIN if the remaining count reaches 0 or abort=1, else FILL.
- abort during RD: the RD completes, no WR is issued, next state is FIN, aborted=1.
- abort during WR or FILL: that write completes (counted in words_done), then FIN with aborted=1.
- FIN: done=1 for exactly one cycle, no memory access, next state IDLE.
- Throughput: copy takes 2 cycles/word, fill takes 1 cycle/word. done is asserted 2N+1 (copy) or N+1 (fill) cycles after the start edge.
- Pointers wrap modulo 2^ADDR_W (0x1FFF+1 = 0x0000).
- Overlapping ranges are copied in ascending address order with no overlap protection.
- length > 2^ADDR_W: transfer proceeds and wraps; no error is flagged.
- mem_chipselect is 0 in IDLE and FIN.
- checksum and words_done hold their values after done until the next accepted start.

Test Plan:
- Copy: preload RAM[0x0010..0x0013] = 1,2,3,4; start, mode=0, src=0x0010, dst=0x0100, len=4. Required: RAM[0x0100..0x0103] = 1,2,3,4; done at cycle 9 after start; checksum=10; words_done=4; aborted=0.
- Fill wrap: mode=1, dst=0x1FFE, len=3, fill=0xA5A5A5A5. Required: writes to 0x1FFE, 0x1FFF, 0x0000; done at cycle 4; checksum=0xF0F0F0EF.
- Zero length: start with len=0. Required: busy high 1 cycle, done pulses the next cycle, mem_chipselect never asserted.
- Start while busy: second start with different dst during a copy of len=8. Required: ignored; only the first transfer's writes occur.
- Abort: copy len=8, assert abort during the 3rd WR. Required: exactly 3 words written, words_done=3, aborted=1, one done pulse.
- Async reset mid-fill: drop reset_n during FILL. Required: all outputs return to reset values immediately; a new start after release runs normally.

Source files
------------

// File: rtl/core_mem_copy_master.sv
// ---------------------------------------------------------------------------
// core_mem_copy_master
//
// Avalon-MM master for the single-port on-chip RAM beside a core. It copies
// a block of words from one address range to another in that RAM, or fills
// a range with a constant. It also keeps a running checksum of every word
// it writes.
//
// Ports
//   clk, reset_n     clock, asynchronous active-low reset
//   start            one-cycle command strobe, only honoured in IDLE
//   mode             0 = copy, 1 = fill
//   src_addr         copy source word address
//   dst_addr         destination word address
//   length           number of words to transfer (0 completes immediately)
//   fill_value       word written in fill mode
//   abort            stop after the current memory access
//   busy             high in every state except IDLE
//   done             one-cycle completion pulse (FIN state)
//   aborted          last transfer was ended by abort
//   checksum         sum of words written, modulo 2^DATA_W
//   words_done       words written by the last/current transfer
//   mem_*            Avalon-MM master port toward the RAM slave
//
// Memory protocol: an access happens in every cycle where mem_chipselect is
// high. mem_write selects write or read. The slave has no waitrequest, so
// every access completes in the cycle it is presented. Read data is on
// mem_readdata in the cycle after the read access (fixed latency 1).
// ---------------------------------------------------------------------------
module core_mem_copy_master #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 14
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_W-1:0]     src_addr,
    input  logic [ADDR_W-1:0]     dst_addr,
    input  logic [LEN_W-1:0]      length,
    input  logic [DATA_W-1:0]     fill_value,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [DATA_W-1:0]     checksum,
    output logic [LEN_W-1:0]      words_done,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_FILL = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [LEN_W-1:0]  LEN_ONE  = 1;
    localparam logic [LEN_W-1:0]  LEN_ZERO = 0;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   src_q;
    logic [ADDR_W-1:0]   dst_q;
    logic [LEN_W-1:0]    remain_q;
    logic [DATA_W-1:0]   fill_q;
    logic                last_word;

    // The mode is not kept in a register: choosing RD or FILL on start
    // already records it in the state.
    assign last_word = (remain_q == LEN_ONE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and memory-port outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_writedata  = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length == LEN_ZERO) begin
                        state_d = S_FIN;
                    end else if (mode) begin
                        state_d = S_FILL;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end

            S_RD: begin
                mem_chipselect = 1'b1;
                mem_address    = src_q;
                // An abort here lets the read finish but drops the write.
                state_d        = abort ? S_FIN : S_WR;
            end

            S_WR: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_address    = dst_q;
                // Read data from the previous RD cycle goes straight through.
                mem_writedata  = mem_readdata;
                state_d        = (last_word || abort) ? S_FIN : S_RD;
            end

            S_FILL: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_address    = dst_q;
                mem_writedata  = fill_q;
                state_d        = (last_word || abort) ? S_FIN : S_FILL;
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Working registers, checksum and status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q      <= '0;
            dst_q      <= '0;
            remain_q   <= '0;
            fill_q     <= '0;
            checksum   <= '0;
            words_done <= '0;
            aborted    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        src_q      <= src_addr;
                        dst_q      <= dst_addr;
                        remain_q   <= length;
                        fill_q     <= fill_value;
                        checksum   <= '0;
                        words_done <= '0;
                        aborted    <= 1'b0;
                    end
                end

                S_RD: begin
                    if (abort) begin
                        aborted <= 1'b1;
                    end
                end

                S_WR, S_FILL: begin
                    // mem_writedata is the word being written in both states.
                    checksum   <= checksum + mem_writedata;
                    dst_q      <= dst_q + ADDR_ONE;
                    remain_q   <= remain_q - LEN_ONE;
                    words_done <= words_done + LEN_ONE;
                    if (state_q == S_WR) begin
                        src_q <= src_q + ADDR_ONE;
                    end
                    if (abort) begin
                        aborted <= 1'b1;
                    end
                end

                default: begin
                end
            endcase
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_FIN);
    assign mem_clken      = busy;
    assign mem_byteenable = '1;

endmodule

// File: tb/tb_core_mem_copy_master.sv
// ---------------------------------------------------------------------------
// tb_core_mem_copy_master
//
// Bench for core_mem_copy_master. It wraps the DUT in a latency-1 RAM model
// and runs a table of directed transfers. Each entry in the table holds the
// hand-computed checksum, words_done, aborted flag, cycle count and number
// of chipselect cycles. A reference memory builds the expected write
// sequence, and every write is compared against it. Reset behaviour, both
// at power-up and in the middle of a fill, is covered by hand-written
// sequences.
// ---------------------------------------------------------------------------
module tb_core_mem_copy_master;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 14;
    localparam int MAX_CYC = 200;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic                 start;
    logic                 mode;
    logic [ADDR_W-1:0]    src_addr;
    logic [ADDR_W-1:0]    dst_addr;
    logic [LEN_W-1:0]     length;
    logic [DATA_W-1:0]    fill_value;
    logic                 abort;
    logic                 busy;
    logic                 done;
    logic                 aborted;
    logic [DATA_W-1:0]    checksum;
    logic [LEN_W-1:0]     words_done;
    logic [ADDR_W-1:0]    mem_address;
    logic [DATA_W/8-1:0]  mem_byteenable;
    logic                 mem_chipselect;
    logic                 mem_write;
    logic [DATA_W-1:0]    mem_writedata;
    logic                 mem_clken;
    logic [DATA_W-1:0]    mem_readdata;

    core_mem_copy_master #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .mode          (mode),
        .src_addr      (src_addr),
        .dst_addr      (dst_addr),
        .length        (length),
        .fill_value    (fill_value),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted),
        .checksum      (checksum),
        .words_done    (words_done),
        .mem_address   (mem_address),
        .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect),
        .mem_write     (mem_write),
        .mem_writedata (mem_writedata),
        .mem_clken     (mem_clken),
        .mem_readdata  (mem_readdata)
    );

    // ---------------- RAM slave model (read latency 1) ----------------
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];

    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                ram[mem_address] <= mem_writedata;
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    // Write monitor feeding the scoreboard
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [ADDR_W+DATA_W-1:0] obs_q[$];

    always @(negedge clk) begin
        if (mem_chipselect && mem_write) begin
            obs_q.push_back({mem_address, mem_writedata});
        end
    end

    // ---------------- scoreboard counters ----------------
    int n_chk;
    int n_pass;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_chk++;
        if (act === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ram[a]     <= d;
        ref_mem[a]  = d;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic              mode;
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
        logic [LEN_W-1:0]  len;
        logic [DATA_W-1:0] fill;
        int                abort_cyc;    // cycle whose state sees abort=1 (0 = none)
        int                restart_cyc;  // cycle in which a stray start is driven
        logic [DATA_W-1:0] exp_sum;
        logic [LEN_W-1:0]  exp_wd;
        logic              exp_ab;
        int                exp_cyc;      // done seen this many edges after capture
        int                exp_cs;       // cycles with mem_chipselect high
    } vec_t;

    vec_t vecs[10];

    // ---------------- driver ----------------
    task automatic run_vec(input string tag, input vec_t v);
        int  cyc;
        int  cs_n;
        bit  got;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] sa;
        logic [DATA_W-1:0] d;

        // Expected writes from the reference memory, in ascending order
        exp_q.delete();
        for (int i = 0; i < int'(v.exp_wd); i++) begin
            a = v.dst + ADDR_W'(i);
            if (v.mode) begin
                d = v.fill;
            end else begin
                sa = v.src + ADDR_W'(i);
                d  = ref_mem[sa];
            end
            ref_mem[a] = d;
            exp_q.push_back({a, d});
        end

        @(negedge clk);
        obs_q.delete();
        mode       = v.mode;
        src_addr   = v.src;
        dst_addr   = v.dst;
        length     = v.len;
        fill_value = v.fill;
        start      = 1'b1;
        cyc  = 0;
        cs_n = 0;
        got  = 1'b0;
        while (!got && cyc < MAX_CYC) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = (cyc == v.restart_cyc);
            if (start) begin
                dst_addr = 13'h0700;
            end
            abort = (cyc == v.abort_cyc);
            if (mem_chipselect) begin
                cs_n++;
            end
            if (done) begin
                got = 1'b1;
            end
        end
        start = 1'b0;
        abort = 1'b0;

        check({tag, ".done_seen"}, 64'(got), 64'd1);
        check({tag, ".cycles"}, 64'(cyc), 64'(v.exp_cyc));
        check({tag, ".cs_cycles"}, 64'(cs_n), 64'(v.exp_cs));
        check({tag, ".checksum"}, 64'(checksum), 64'(v.exp_sum));
        check({tag, ".words_done"}, 64'(words_done), 64'(v.exp_wd));
        check({tag, ".aborted"}, 64'(aborted), 64'(v.exp_ab));
        check({tag, ".wr_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check({tag, ".wr_entry"}, 64'(obs_q[i]), 64'(exp_q[i]));
        end

        // done must be a single-cycle pulse, followed by IDLE
        @(posedge clk);
        @(negedge clk);
        check({tag, ".done_pulse"}, 64'(done), 64'd0);
        check({tag, ".idle_after"}, 64'(busy), 64'd0);
        check({tag, ".sum_hold"}, 64'(checksum), 64'(v.exp_sum));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".busy"}, 64'(busy), 64'd0);
        check({tag, ".done"}, 64'(done), 64'd0);
        check({tag, ".aborted"}, 64'(aborted), 64'd0);
        check({tag, ".checksum"}, 64'(checksum), 64'd0);
        check({tag, ".words_done"}, 64'(words_done), 64'd0);
        check({tag, ".cs"}, 64'(mem_chipselect), 64'd0);
        check({tag, ".write"}, 64'(mem_write), 64'd0);
        check({tag, ".address"}, 64'(mem_address), 64'd0);
        check({tag, ".writedata"}, 64'(mem_writedata), 64'd0);
        check({tag, ".clken"}, 64'(mem_clken), 64'd0);
        check({tag, ".byteenable"}, 64'(mem_byteenable), 64'hF);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vec_t rv;
        n_chk      = 0;
        n_pass     = 0;
        reset_n    = 1'b0;
        start      = 1'b0;
        mode       = 1'b0;
        src_addr   = '0;
        dst_addr   = '0;
        length     = '0;
        fill_value = '0;
        abort      = 1'b0;

        // Source data for the copy vectors
        for (int i = 0; i < 4; i++) poke(13'h0010 + 13'(i), 32'(i + 1));
        poke(13'h0300, 32'd7);
        poke(13'h0301, 32'd9);
        poke(13'h0302, 32'd11);
        for (int i = 0; i < 8; i++) poke(13'h0020 + 13'(i), 32'((i + 1) * 16));

        //            mode  src      dst      len  fill           abrt rst  sum            wd  ab  cyc cs
        vecs[0] = '{1'b0, 13'h0010, 13'h0100, 14'd4, 32'h0,        0, 0, 32'd10,        14'd4, 1'b0, 9, 8};
        vecs[1] = '{1'b1, 13'h0000, 13'h1FFE, 14'd3, 32'hA5A5A5A5, 0, 0, 32'hF0F0F0EF,  14'd3, 1'b0, 4, 3};
        vecs[2] = '{1'b0, 13'h0010, 13'h0100, 14'd0, 32'h0,        0, 0, 32'd0,         14'd0, 1'b0, 1, 0};
        vecs[3] = '{1'b1, 13'h0000, 13'h0200, 14'd2, 32'h80000000, 0, 0, 32'd0,         14'd2, 1'b0, 3, 2};
        // Overlapping ranges: the first word ripples up through the block
        vecs[4] = '{1'b0, 13'h0300, 13'h0301, 14'd3, 32'h0,        0, 0, 32'd21,        14'd3, 1'b0, 7, 6};
        // Source pointer wrap, reading words left by the fill in vecs[1]
        vecs[5] = '{1'b0, 13'h1FFF, 13'h0FFF, 14'd2, 32'h0,        0, 0, 32'h4B4B4B4A,  14'd2, 1'b0, 5, 4};
        // Abort during the 3rd WR (cycle 6)
        vecs[6] = '{1'b0, 13'h0020, 13'h0500, 14'd8, 32'h0,        6, 0, 32'h60,        14'd3, 1'b1, 7, 6};
        // Abort during the 3rd RD (cycle 5): that read completes, no write follows it
        vecs[7] = '{1'b0, 13'h0020, 13'h0800, 14'd8, 32'h0,        5, 0, 32'h30,        14'd2, 1'b1, 6, 5};
        // Stray start with dst=0x700 in mid-copy is ignored
        vecs[8] = '{1'b0, 13'h0020, 13'h0600, 14'd8, 32'h0,        0, 4, 32'h240,       14'd8, 1'b0, 17, 16};
        vecs[9] = '{1'b1, 13'h0000, 13'h1FFF, 14'd1, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF,  14'd1, 1'b0, 2, 1};

        #7;
        check_reset_state("reset");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Copy destination contents after the first copy and the overlap copy
        check("mem_copy_last", 64'(ram[13'h0103]), 64'd4);
        check("mem_overlap_top", 64'(ram[13'h0303]), 64'd7);
        check("mem_abort_untouched", 64'(ram[13'h0503] === 32'h40), 64'd0);

        // Async reset in the middle of a fill
        @(negedge clk);
        mode       = 1'b1;
        dst_addr   = 13'h0400;
        length     = 14'd10;
        fill_value = 32'h1234;
        start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("midfill.busy", 64'(busy), 64'd1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state("midfill_reset");
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) ref_mem[13'h0400 + 13'(i)] = 32'h1234;

        rv = '{1'b1, 13'h0000, 13'h0400, 14'd2, 32'h5, 0, 0, 32'hA, 14'd2, 1'b0, 3, 2};
        run_vec("post_reset", rv);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
